// File: rtl/system86_video_pkg.sv
// Shared System86 video timing constants and small decode helpers.
// Used by the raster timing generator and the layer fetch/videogen stages.
package system86_video_pkg;

    localparam int VID_CNT_W = 9;

    // Default System86 raster timing (6.144 MHz pixel clock)
    localparam int unsigned VID_H_TOTAL      = 384;
    localparam int unsigned VID_H_ACTIVE     = 288;
    localparam int unsigned VID_H_SYNC_START = 312;
    localparam int unsigned VID_H_SYNC_WIDTH = 32;
    localparam int unsigned VID_V_TOTAL      = 264;
    localparam int unsigned VID_V_ACTIVE     = 224;
    localparam int unsigned VID_V_SYNC_START = 240;
    localparam int unsigned VID_V_SYNC_WIDTH = 3;

    typedef logic [VID_CNT_W-1:0] vid_cnt_t;

    // True when cnt lies in [lo, lo+len)
    function automatic logic in_win(input vid_cnt_t cnt, input int unsigned lo,
                                    input int unsigned len);
        return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/video_timing_subsystem_if.sv
// Raster timing bundle: enable/flip control in, counts, blanks, syncs and
// the frame interrupt strobe out. master = timing generator, slave = consumer.
interface video_timing_subsystem_if
    import system86_video_pkg::*;
();
    logic     enable;
    logic     FLIP;
    vid_cnt_t HCOUNT;
    vid_cnt_t VCOUNT;
    logic     nHBLANK;
    logic     nVBLANK;
    logic     nBLANK;
    logic     nBLANK_D;
    logic     nHSYNC;
    logic     nVSYNC;
    logic     SYNC;
    logic     VBLANK_IRQ;

    modport master (
        input  enable, FLIP,
        output HCOUNT, VCOUNT, nHBLANK, nVBLANK, nBLANK, nBLANK_D,
               nHSYNC, nVSYNC, SYNC, VBLANK_IRQ
    );

    modport slave (
        output enable, FLIP,
        input  HCOUNT, VCOUNT, nHBLANK, nVBLANK, nBLANK, nBLANK_D,
               nHSYNC, nVSYNC, SYNC, VBLANK_IRQ
    );
endinterface

// File: rtl/video_delay_line.sv
// Enabled shift-register delay line, reset to all-ones (inactive for the
// active-low signals it carries). DEPTH=0 is a plain wire.
module video_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk_i, rst_ni, en_i};
        assign dout_o    = din_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        // Shift one stage per enabled clock; stage 0 takes the input
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= '1;
            end else if (en_i) begin
                stage_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_subsystem.sv
// System86 raster timing generator: H/V counters, blanks, syncs, delayed
// nBLANK for the CLUT nCLR and the once-per-frame VBLANK interrupt strobe.
// All outputs are registered from the next-state counters so they line up
// with HCOUNT/VCOUNT in the same cycle.
// Optional: VIDEO_TIMING_FLIP_EN mirrors the active-area counts while the
// frame-latched FLIP is set.
module video_timing_subsystem
    import system86_video_pkg::*;
#(
    parameter int unsigned H_TOTAL      = VID_H_TOTAL,
    parameter int unsigned H_ACTIVE     = VID_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VID_H_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = VID_H_SYNC_WIDTH,
    parameter int unsigned V_TOTAL      = VID_V_TOTAL,
    parameter int unsigned V_ACTIVE     = VID_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VID_V_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = VID_V_SYNC_WIDTH,
    parameter int unsigned BLANK_DELAY  = 1
) (
    input logic                      CLK_6MD,
    input logic                      nRESET,
    video_timing_subsystem_if.master vid
);

    localparam int W = VID_CNT_W;

    // Counters are 9 bits wide; anything larger cannot be represented
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("H_TOTAL/V_TOTAL must not exceed 512");
    end
    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL ||
        V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_bad_sync
        $error("sync window exceeds line/frame total");
    end
    if (BLANK_DELAY > 7) begin : g_bad_delay
        $error("BLANK_DELAY must be 0..7");
    end

    localparam vid_cnt_t H_LAST = W'(H_TOTAL - 1);
    localparam vid_cnt_t V_LAST = W'(V_TOTAL - 1);

    vid_cnt_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic     hblank_n_q, vblank_n_q, blank_n_q, hsync_n_q, vsync_n_q, sync_q, irq_q;
    logic     hblank_n_d, vblank_n_d, hsync_n_d, vsync_n_d, irq_d;
    logic     frame_wrap;

    // Advance values of the counters; only loaded on enabled edges
    always_comb begin
        hcnt_d     = hcnt_q + 1'b1;
        vcnt_d     = vcnt_q;
        frame_wrap = 1'b0;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d     = '0;
                frame_wrap = 1'b1;
            end else begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end
    end

    // Decode the next count so registered outputs match the count they sit beside
    always_comb begin
        hblank_n_d = (32'(hcnt_d) < H_ACTIVE);
        vblank_n_d = (32'(vcnt_d) < V_ACTIVE);
        hsync_n_d  = !in_win(hcnt_d, H_SYNC_START, H_SYNC_WIDTH);
        vsync_n_d  = !in_win(vcnt_d, V_SYNC_START, V_SYNC_WIDTH);
        irq_d      = (hcnt_d == '0) && (32'(vcnt_d) == V_ACTIVE);
    end

    // Counter and decoded output registers; everything holds while enable is low
    always_ff @(posedge CLK_6MD or negedge nRESET) begin
        if (!nRESET) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            hblank_n_q <= 1'b1;
            vblank_n_q <= 1'b1;
            blank_n_q  <= 1'b1;
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            sync_q     <= 1'b1;
            irq_q      <= 1'b0;
        end else if (vid.enable) begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            hblank_n_q <= hblank_n_d;
            vblank_n_q <= vblank_n_d;
            blank_n_q  <= hblank_n_d & vblank_n_d;
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
            sync_q     <= hsync_n_d & vsync_n_d;
            irq_q      <= irq_d;
        end
    end

`ifdef VIDEO_TIMING_FLIP_EN
    localparam vid_cnt_t H_ACT_LAST = W'(H_ACTIVE - 1);
    localparam vid_cnt_t V_ACT_LAST = W'(V_ACTIVE - 1);

    logic     flip_q, flip_d;
    vid_cnt_t hout_q, hout_d, vout_q, vout_d;

    // FLIP only takes effect from a frame boundary; mirror inside the active area
    always_comb begin
        flip_d = frame_wrap ? vid.FLIP : flip_q;
        hout_d = hcnt_d;
        vout_d = vcnt_d;
        if (flip_d && hblank_n_d && vblank_n_d) begin
            hout_d = H_ACT_LAST - hcnt_d;
            vout_d = V_ACT_LAST - vcnt_d;
        end
    end

    // Latched flip state and mirrored count outputs
    always_ff @(posedge CLK_6MD or negedge nRESET) begin
        if (!nRESET) begin
            flip_q <= 1'b0;
            hout_q <= '0;
            vout_q <= '0;
        end else if (vid.enable) begin
            flip_q <= flip_d;
            hout_q <= hout_d;
            vout_q <= vout_d;
        end
    end

    assign vid.HCOUNT = hout_q;
    assign vid.VCOUNT = vout_q;
`else
    logic unused_ok;
    assign unused_ok  = &{1'b0, vid.FLIP, frame_wrap};
    assign vid.HCOUNT = hcnt_q;
    assign vid.VCOUNT = vcnt_q;
`endif

    assign vid.nHBLANK    = hblank_n_q;
    assign vid.nVBLANK    = vblank_n_q;
    assign vid.nBLANK     = blank_n_q;
    assign vid.nHSYNC     = hsync_n_q;
    assign vid.nVSYNC     = vsync_n_q;
    assign vid.SYNC       = sync_q;
    assign vid.VBLANK_IRQ = irq_q;

    video_delay_line #(
        .WIDTH (1),
        .DEPTH (int'(BLANK_DELAY))
    ) u_blank_dly (
        .clk_i  (CLK_6MD),
        .rst_ni (nRESET),
        .en_i   (vid.enable),
        .din_i  (blank_n_q),
        .dout_o (vid.nBLANK_D)
    );

endmodule

// File: tb/tb_video_timing_subsystem.sv
// Directed bench for video_timing_subsystem. Horizontal timing is the
// System86 default; the frame is shortened to 40 lines so a whole frame fits
// the cycle budget, and BLANK_DELAY=3 exercises the nBLANK_D pipeline.
module tb_video_timing_subsystem;
    import system86_video_pkg::*;

    localparam int HT = 384, HA = 288, HSS = 312, HSW = 32;
    localparam int VT = 40,  VA = 24,  VSS = 30,  VSW = 3;
    localparam int BD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_timing_subsystem_if vif();

    video_timing_subsystem #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .BLANK_DELAY(BD)
    ) dut (
        .CLK_6MD (clk),
        .nRESET  (rst_n),
        .vid     (vif)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // raster model: raw position, latched flip, nBLANK history (bit 0 newest)
    int          mh, mv;
    bit          mflip;
    logic [BD-1:0] bhist;

    task automatic model_reset();
        mh = 0; mv = 0; mflip = 1'b0; bhist = '1;
    endtask

    task automatic model_adv();
        logic prev_blank;
        prev_blank = (mh < HA) && (mv < VA);
        bhist = {bhist[BD-2:0], prev_blank};
        if (mh == HT-1) begin
            mh = 0;
            if (mv == VT-1) begin mv = 0; mflip = vif.FLIP; end
            else mv = mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic check_all();
        int  hx, vx;
        logic hb, vb, hs, vs;
        hx = mh; vx = mv;
`ifdef VIDEO_TIMING_FLIP_EN
        if (mflip && mh < HA && mv < VA) begin hx = HA-1-mh; vx = VA-1-mv; end
`endif
        hb = (mh < HA);
        vb = (mv < VA);
        hs = !(mh >= HSS && mh < HSS+HSW);
        vs = !(mv >= VSS && mv < VSS+VSW);
        chk("hcount",   32'(vif.HCOUNT),     hx);
        chk("vcount",   32'(vif.VCOUNT),     vx);
        chk("nhblank",  32'(vif.nHBLANK),    32'(hb));
        chk("nvblank",  32'(vif.nVBLANK),    32'(vb));
        chk("nblank",   32'(vif.nBLANK),     32'(hb & vb));
        chk("nblank_d", 32'(vif.nBLANK_D),   32'(bhist[BD-1]));
        chk("nhsync",   32'(vif.nHSYNC),     32'(hs));
        chk("nvsync",   32'(vif.nVSYNC),     32'(vs));
        chk("sync",     32'(vif.SYNC),       32'(hs & vs));
        chk("irq",      32'(vif.VBLANK_IRQ), 32'(mh == 0 && mv == VA));
    endtask

    // one clock: model follows enabled edges, outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        if (vif.enable) model_adv();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until(input string tag, input int h, input int v, input int limit);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < limit) begin tick(); n++; end
        if (n >= limit) chk({tag, "_timeout"}, 32'(n), 32'(limit - 1));
    endtask

    function automatic logic [25:0] snap();
        return {vif.HCOUNT, vif.VCOUNT, vif.nHBLANK, vif.nVBLANK, vif.nBLANK,
                vif.nBLANK_D, vif.nHSYNC, vif.nVSYNC, vif.SYNC, vif.VBLANK_IRQ};
    endfunction

    initial begin
        int          irq_cnt, irq_h, irq_v, vs_cyc, vs_first, len;
        logic [25:0] s0;

        vif.enable = 1'b1;
        vif.FLIP   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();                         // reset values
        rst_n = 1'b1;

        // one full line
        for (int i = 1; i <= HT; i++) begin
            tick();
            chk("line_h", 32'(vif.HCOUNT), 32'(i % HT));
            if (i == 1)   chk("first_adv",  32'(vif.HCOUNT),   1);
            if (i == 287) chk("hblank_287", 32'(vif.nHBLANK),  1);
            if (i == 288) chk("hblank_288", 32'(vif.nHBLANK),  0);
            if (i == 290) chk("blankd_290", 32'(vif.nBLANK_D), 1);
            if (i == 291) chk("blankd_291", 32'(vif.nBLANK_D), 0);
            if (i == 311) chk("hsync_311",  32'(vif.nHSYNC),   1);
            if (i == 312) chk("hsync_312",  32'(vif.nHSYNC),   0);
            if (i == 343) chk("hsync_343",  32'(vif.nHSYNC),   0);
            if (i == 344) chk("hsync_344",  32'(vif.nHSYNC),   1);
            if (i == 383) chk("v_before",   32'(vif.VCOUNT),   0);
            if (i == 384) chk("v_wrap",     32'(vif.VCOUNT),   1);
        end

        // one full frame
        irq_cnt = 0; irq_h = -1; irq_v = -1; vs_cyc = 0; vs_first = -1;
        for (int i = 0; i < HT*VT; i++) begin
            tick();
            if (vif.VBLANK_IRQ) begin
                irq_cnt++; irq_h = int'(vif.HCOUNT); irq_v = int'(vif.VCOUNT);
            end
            if (!vif.nVSYNC) begin
                vs_cyc++;
                if (vs_first < 0) vs_first = int'(vif.VCOUNT);
            end
        end
        chk("irq_count",   32'(irq_cnt),  1);
        chk("irq_v",       32'(irq_v),    VA);
        chk("irq_h",       32'(irq_h),    0);
        chk("vsync_cyc",   32'(vs_cyc),   VSW*HT);
        chk("vsync_first", 32'(vs_first), VSS);

        // enable low for 10 clocks at HCOUNT=100
        run_until("pause", 100, 1, 2*HT);
        s0 = snap();
        vif.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold", 32'(snap()), 32'(s0));
        end
        vif.enable = 1'b1;
        len = 0;
        do begin tick(); len++; end while (int'(vif.HCOUNT) != 100 && len < 2*HT);
        chk("line_len", 32'(len), HT);

        // IRQ pulse freezes with enable, clears on the next enabled edge
        run_until("irq", 0, VA, HT*VT + HT);
        chk("irq_on", 32'(vif.VBLANK_IRQ), 1);
        vif.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("irq_hold", 32'(vif.VBLANK_IRQ), 1);
        end
        vif.enable = 1'b1;
        tick();
        chk("irq_clear", 32'(vif.VBLANK_IRQ), 0);

        // FLIP raised mid-frame: ignored until the next frame starts
        vif.FLIP = 1'b1;
        run_until("flip_mid", 10, VA+2, HT*VT);
        chk("flip_midframe_h", 32'(vif.HCOUNT), 10);
        run_until("flip_wrap", 0, 0, HT*VT + HT);
`ifdef VIDEO_TIMING_FLIP_EN
        chk("flip_h0", 32'(vif.HCOUNT), HA-1);
        chk("flip_v0", 32'(vif.VCOUNT), VA-1);
`else
        chk("flip_h0", 32'(vif.HCOUNT), 0);
        chk("flip_v0", 32'(vif.VCOUNT), 0);
`endif
        vif.FLIP = 1'b0;

        // asynchronous reset mid-frame, away from any clock edge
        run_until("rst_pos", 200, 15, HT*VT);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_h",     32'(vif.HCOUNT),     0);
        chk("rst_v",     32'(vif.VCOUNT),     0);
        chk("rst_hb",    32'(vif.nHBLANK),    1);
        chk("rst_vb",    32'(vif.nVBLANK),    1);
        chk("rst_b",     32'(vif.nBLANK),     1);
        chk("rst_bd",    32'(vif.nBLANK_D),   1);
        chk("rst_hs",    32'(vif.nHSYNC),     1);
        chk("rst_vs",    32'(vif.nVSYNC),     1);
        chk("rst_sync",  32'(vif.SYNC),       1);
        chk("rst_irq",   32'(vif.VBLANK_IRQ), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("restart_h", 32'(vif.HCOUNT), 1);
        chk("restart_v", 32'(vif.VCOUNT), 0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_subsystem.md
Name: video_timing_subsystem

Overview:
- Generates System86 raster timing from the 6.144 MHz pixel clock.
  - Horizontal and vertical counters.
  - Blanking, HSYNC/VSYNC, composite SYNC.
  - Pipelined active-low blank that drives nCLR of the downstream CLUT/videogen stage.
- Sits directly upstream of the videogen subsystem and alongside the tile/sprite layer fetch, which consume HCOUNT/VCOUNT.
- Also supplies the once-per-frame VBLANK strobe to the CPU interrupt logic.

Parameters:
- H_TOTAL, 384, pixel clocks per line
- H_ACTIVE, 288, visible pixels per line; counts 0..H_ACTIVE-1
- H_SYNC_START, 312, HCOUNT at which nHSYNC asserts
- H_SYNC_WIDTH, 32, nHSYNC low duration in clocks
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines; counts 0..V_ACTIVE-1
- V_SYNC_START, 240, VCOUNT at which nVSYNC asserts
- V_SYNC_WIDTH, 3, nVSYNC low duration in lines
- BLANK_DELAY, 1, clocks of delay (0..7) from nBLANK to nBLANK_D, matching the downstream pipeline

Ports:
- CLK_6MD  in  1  pixel clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- enable  in  1  clock enable; counters and all registers hold when low
- HCOUNT  out  9  horizontal pixel count
- VCOUNT  out  9  line count
- nHBLANK  out  1  low outside the horizontal active area
- nVBLANK  out  1  low outside the vertical active area
- nBLANK  out  1  nHBLANK AND nVBLANK
- nBLANK_D  out  1  nBLANK delayed BLANK_DELAY enabled clocks; connects to videogen nCLR
- nHSYNC  out  1  active-low horizontal sync
- nVSYNC  out  1  active-low vertical sync
- SYNC  out  1  active-low composite sync = nHSYNC AND nVSYNC
- VBLANK_IRQ  out  1  one-enabled-clock pulse at start of vertical blank
- FLIP  in  1  screen flip request; used only with the optional feature

Behaviour:
- Clock and reset:
  - Single clock, CLK_6MD.
  - nRESET is asynchronous and active-low.
- Reset values:
  - HCOUNT=0, VCOUNT=0, VBLANK_IRQ=0.
  - nHBLANK=1, nVBLANK=1, nBLANK=1, nHSYNC=1, nVSYNC=1, SYNC=1.
  - Every nBLANK_D delay stage = 1.
  - First enabled edge after reset release advances HCOUNT to 1.
- Counting:
  - Counters advance only on rising edges with enable=1.
  - HCOUNT increments and wraps from H_TOTAL-1 to 0.
  - VCOUNT increments only on the HCOUNT wrap edge; it wraps from V_TOTAL-1 to 0 on that same edge.
- Output alignment:
  - All outputs are registered.
  - Each output decodes the counter value presented in the same cycle (zero latency relative to HCOUNT/VCOUNT); implement by decoding next-state.
- Decode rules:
  - nHBLANK=1 iff HCOUNT<H_ACTIVE.
  - nVBLANK=1 iff VCOUNT<V_ACTIVE.
  - nHSYNC=0 iff H_SYNC_START <= HCOUNT < H_SYNC_START+H_SYNC_WIDTH.
  - nVSYNC=0 iff V_SYNC_START <= VCOUNT < V_SYNC_START+V_SYNC_WIDTH, for the whole line including the blanked portion.
- VBLANK_IRQ:
  - High for exactly the cycle where VCOUNT==V_ACTIVE and HCOUNT==0.
  - Once per frame, never during reset.
- nBLANK_D:
  - Shift register clocked with enable.
  - BLANK_DELAY=0 means nBLANK_D equals nBLANK combinationally from the registered nBLANK.
- Reset mid-frame: all state returns asynchronously to the reset values; the frame restarts at (0,0).
- Width rule: parameters must satisfy H_TOTAL, V_TOTAL <= 512. Elaboration fails otherwise, and also if a sync window exceeds its total.
- enable low mid-line: all outputs freeze, including an active VBLANK_IRQ pulse, which then persists until the next enabled edge clears it.

Optional Feature:
- Macro: VIDEO_TIMING_FLIP_EN
- Defined:
  - FLIP is sampled into a register only on the frame wrap edge (VCOUNT V_TOTAL-1 -> 0). It is never sampled mid-frame.
  - While the registered flip is 1 and inside the active area, HCOUNT outputs H_ACTIVE-1-h and VCOUNT outputs V_ACTIVE-1-v.
  - Outside the active area the counts are unflipped.
  - Sync, blank and IRQ timing are unchanged.
- Undefined: the FLIP port exists but is ignored; counts are never mirrored.

Decomposition:
- Shared package system86_video_pkg holds:
  - The default timing constants (H_TOTAL, H_ACTIVE, sync positions/widths, V_*).
  - The counter width constant VID_CNT_W=9.
- Blank delay line as sub-module video_delay_line, with parameters WIDTH and DEPTH, enable and asynchronous active-low reset to all-ones. It is reused later for the sprite/tile pipeline alignment.

Test Plan:
- Release nRESET with enable=1, run 384 clocks -> HCOUNT 0..383 then 0; VCOUNT 0->1 on the wrap edge; nHBLANK falls when HCOUNT=288; nHSYNC low for HCOUNT 312..343 only.
- Run one full frame (384*264=101376 clocks) -> VBLANK_IRQ high exactly once, at VCOUNT=224/HCOUNT=0; nVSYNC low on lines 240..242; SYNC is the AND of the syncs at every cycle.
- BLANK_DELAY=3, sweep one line -> nBLANK_D edges lag nBLANK edges by exactly 3 clocks.
- Toggle enable low for 10 clocks at HCOUNT=100 -> all outputs hold for those 10 clocks; line length measured in enabled clocks is still 384.
- Assert nRESET at VCOUNT=150/HCOUNT=200, off-edge -> outputs immediately return to reset values; after release the counts restart at 0.
- VIDEO_TIMING_FLIP_EN defined, FLIP raised at mid-frame VCOUNT=100 -> no change that frame; next frame, HCOUNT=287 is observed at raw position 0 and VCOUNT=223 on raw line 0.
